// File: rtl/systolic_gram.sv
// Two-column triangular systolic array accumulating the upper-triangle Gram terms
// sum(x01*x02) and sum(x02*x02), with each output cell forwarding its column-2 stream.

// Boundary cell (1,1): the column-1 stream only needs to be registered.
module gram_pass_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_a,
  output logic [DATA_W-1:0] o_h
);

  logic [DATA_W-1:0] r_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
    end else begin
      r_h <= i_a;
    end
  end

  assign o_h = r_h;

endmodule

// Internal cell (1,2): cross-product accumulator; passes column 2 downward.
module gram_cross_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_h,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_v
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_v;
  logic [DATA_W-1:0] w_prod;

  // Unsigned product truncated to DATA_W; accumulation wraps modulo 2^DATA_W.
  assign w_prod = i_h * i_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_v   <= '0;
    end else begin
      r_acc <= r_acc + w_prod;
      r_v   <= i_d;
    end
  end

  assign o_acc = r_acc;
  assign o_v   = r_v;

endmodule

// Boundary cell (2,2): square accumulator of the incoming column-2 stream.
module gram_square_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_v,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_f
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_f;
  logic [DATA_W-1:0] w_sq;

  assign w_sq = i_v * i_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_f   <= '0;
    end else begin
      r_acc <= r_acc + w_sq;
      r_f   <= i_v;
    end
  end

  assign o_acc = r_acc;
  assign o_f   = r_f;

endmodule

module systolic_gram #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x01,
  input  logic [DATA_W-1:0] x02,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c22,
  output logic [DATA_W-1:0] s12,
  output logic [DATA_W-1:0] s22
);

  // Free-running stream: every clock carries a sample pair, no valid/ready.
  logic [DATA_W-1:0] r_a1;
  logic [DATA_W-1:0] r_a2;
  logic [DATA_W-1:0] r_d2;
  logic [DATA_W-1:0] w_h11;
  logic [DATA_W-1:0] w_acc12;
  logic [DATA_W-1:0] w_v12;
  logic [DATA_W-1:0] w_acc22;
  logic [DATA_W-1:0] w_f22;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a1 <= '0;
      r_a2 <= '0;
    end else begin
      r_a1 <= x01;
      r_a2 <= x02;
    end
  end

  // Skew register keeps column 2 aligned with the registered output of cell (1,1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d2 <= '0;
    end else begin
      r_d2 <= r_a2;
    end
  end

  gram_pass_cell #(.DATA_W(DATA_W)) u_cell11 (
    .clk   (clk),
    .rst_n (rst),
    .i_a   (r_a1),
    .o_h   (w_h11)
  );

  gram_cross_cell #(.DATA_W(DATA_W)) u_cell12 (
    .clk   (clk),
    .rst_n (rst),
    .i_h   (w_h11),
    .i_d   (r_d2),
    .o_acc (w_acc12),
    .o_v   (w_v12)
  );

  gram_square_cell #(.DATA_W(DATA_W)) u_cell22 (
    .clk   (clk),
    .rst_n (rst),
    .i_v   (w_v12),
    .o_acc (w_acc22),
    .o_f   (w_f22)
  );

  assign c12 = w_acc12;
  assign s12 = w_v12;
  assign c22 = w_acc22;
  assign s22 = w_f22;

endmodule

// File: tb/tb_systolic_gram.sv
// Directed and random stimulus for systolic_gram; expected outputs are queued per
// driven sample and popped when the pipeline latency has elapsed.
module tb_systolic_gram;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x01;
  logic [W-1:0] x02;
  logic [W-1:0] c12;
  logic [W-1:0] c22;
  logic [W-1:0] s12;
  logic [W-1:0] s22;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp12_q[$];
  logic [2*W-1:0] exp22_q[$];
  logic [W-1:0]   m_c12;
  logic [W-1:0]   m_c22;

  always #5 clk = ~clk;

  systolic_gram #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .x01 (x01),
    .x02 (x02),
    .c12 (c12),
    .c22 (c22),
    .s12 (s12),
    .s22 (s22)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pipeline holds zeros after reset: two slots ahead of cell (1,2), three ahead of (2,2).
  task automatic restart_model();
    exp12_q.delete();
    exp22_q.delete();
    m_c12 = '0;
    m_c22 = '0;
    repeat (2) exp12_q.push_back('0);
    repeat (3) exp22_q.push_back('0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_c12"}, c12, '0);
    check({tag, "_c22"}, c22, '0);
    check({tag, "_s12"}, s12, '0);
    check({tag, "_s22"}, s22, '0);
  endtask

  // Called at a negedge; drives one sample pair, then checks the outputs after the edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    x01 = a;
    x02 = b;
    m_c12 = m_c12 + a * b;
    m_c22 = m_c22 + b * b;
    exp12_q.push_back({m_c12, b});
    exp22_q.push_back({m_c22, b});
    @(negedge clk);
    e = exp12_q.pop_front();
    check("sb_c12", c12, e[2*W-1:W]);
    check("sb_s12", s12, e[W-1:0]);
    e = exp22_q.pop_front();
    check("sb_c22", c22, e[2*W-1:W]);
    check("sb_s22", s22, e[W-1:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  // Asynchronous assertion mid-cycle with nonzero inputs; released on a negedge.
  task automatic apply_reset();
    x01 = W'($urandom_range(1, 1000));
    x02 = W'($urandom_range(1, 1000));
    #1 rst = 1'b0;
    #1 check_zero_outputs("rst_now");
    repeat (3) begin
      @(negedge clk);
      check_zero_outputs("rst_held");
    end
    rst = 1'b1;
    restart_model();
  endtask

  initial begin
    rst = 1'b1;
    x01 = '0;
    x02 = '0;
    restart_model();

    apply_reset();

    // Single impulse
    step(32'd2, 32'd3);
    idle(4);
    check("imp_c12", c12, 32'd6);
    check("imp_c22", c22, 32'd9);
    check("imp_s12", s12, 32'd0);
    check("imp_s22", s22, 32'd0);

    // Back-to-back stream 1..6
    apply_reset();
    for (int i = 1; i <= 6; i++) step(W'(i), W'(i));
    idle(4);
    check("strm_c12", c12, 32'd91);
    check("strm_c22", c22, 32'd91);

    // Truncation and wrap
    apply_reset();
    step(32'h0001_0000, 32'h0001_0000);
    idle(3);
    check("trunc_c12", c12, 32'd0);
    check("trunc_c22", c22, 32'd0);
    step(32'hFFFF_FFFF, 32'd1);
    step(32'hFFFF_FFFF, 32'd1);
    idle(3);
    check("wrap_c12", c12, 32'hFFFF_FFFE);
    check("wrap_c22", c22, 32'd2);

    // Column 2 alone feeds only the square term
    step(32'd0, 32'd5);
    idle(3);
    check("indep_c12", c12, 32'hFFFF_FFFE);
    check("indep_c22", c22, 32'd27);

    // Reset in the middle of a stream discards in-flight samples
    apply_reset();
    for (int i = 1; i <= 3; i++) step(W'(i), W'(i));
    apply_reset();
    for (int i = 4; i <= 6; i++) step(W'(i), W'(i));
    idle(3);
    check("mid_c12", c12, 32'd77);
    check("mid_c22", c22, 32'd77);

    // Random full-width stream
    apply_reset();
    for (int i = 0; i < 40; i++) step($urandom, $urandom);
    for (int i = 0; i < 20; i++) step(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/systolic_gram.md
Name: systolic_gram

Overview:
- Small triangular systolic array that streams two 32-bit data columns and accumulates the upper-triangle cross and square terms of their Gram matrix.
- Column 1 (x01) feeds boundary cell (1,1). Column 2 (x02) feeds internal cell (1,2), then boundary cell (2,2).
- Each output cell exposes its accumulator (c) and its forwarded data stream (s).
- Used as the accumulation front end for the 2-column QR/least-squares datapath.

Parameters:
- DATA_W, 32, width of input samples, accumulators and forwarded streams.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  reset; asynchronous, active-low. Asserting it (0) immediately clears every register.
- x01  input  DATA_W  column-1 sample, sampled every clock.
- x02  input  DATA_W  column-2 sample, sampled every clock, same cycle as x01 (no external skew).
- c12  output  DATA_W  accumulator of cell (1,2): running sum of x01*x02.
- c22  output  DATA_W  accumulator of cell (2,2): running sum of x02*x02.
- s12  output  DATA_W  column-2 data leaving cell (1,2) downward.
- s22  output  DATA_W  column-2 data leaving cell (2,2).

Behaviour:
- Reset: while rst=0, all internal registers and all outputs are 0.
- No valid/handshake signals: every clock is a sample. Zero inputs contribute nothing to the accumulators.
- Arithmetic:
  - Unsigned.
  - Products are truncated to the low DATA_W bits.
  - Accumulators add modulo 2^DATA_W (wrap, no saturation, no overflow flag).
- Pipeline, all stages registered at posedge clk:
  - Stage 0 (input regs): a1 <= x01; a2 <= x02.
  - Cell (1,1) is a pass-through: h11 <= a1.
  - Internal skew register: d2 <= a2 (aligns column 2 with h11).
  - Cell (1,2): acc12 <= acc12 + (h11*d2); v12 <= d2.
  - Cell (2,2): acc22 <= acc22 + (v12*v12); f22 <= v12.
  - Output mapping: c12=acc12, s12=v12, c22=acc22, s22=f22. All outputs are directly registered, with no combinational paths from inputs.
- Latency, for a sample presented before rising edge k:
  - Its x01*x02 product is visible in c12 after edge k+2.
  - x02 appears on s12 after edge k+2.
  - Its x02^2 term is visible in c22 after edge k+3.
  - x02 appears on s22 after edge k+3.
- Accumulators never self-clear; only reset clears them.
- Reset mid-stream: samples already inside the pipeline are discarded. After release, accumulation restarts from 0 with the next sampled inputs.
- Consecutive samples are accepted every cycle (throughput 1 sample pair/clock).

Test Plan:
- Reset: drive rst=0 with arbitrary nonzero x01/x02 -> c12=c22=s12=s22=0 immediately and while held.
- Single impulse: one cycle x01=2, x02=3, then zeros -> s12=3 and c12=6 after edge k+2; s22=3 and c22=9 after edge k+3. Values then hold; s12/s22 return to 0 one cycle later.
- Stream: six consecutive cycles x01=x02=1..6, then zeros -> final c12=91 and c22=91. s12 reproduces 1..6 two cycles after input; s22 reproduces 1..6 three cycles after input.
- Wrap:
  - x01=x02=0x00010000 for one cycle -> c12 and c22 unchanged (product 2^32 truncates to 0).
  - Then x01=0xFFFFFFFF, x02=1 twice -> c12=0xFFFFFFFE.
- Mid-stream reset: assert rst=0 partway through the six-sample stream, then release -> all outputs 0 on assertion. Sums reflect only samples presented after release.
- Independence: x01=0, x02=5 for one cycle -> c12 unchanged, c22 increases by 25.
